// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default widths, Tetris board geometry and
// the read-return tag carried alongside each RAM read.
package fb_pkg;
    localparam int FB_ADDR_W       = 8;
    localparam int FB_DATA_W       = 4;
    localparam int FB_STARVE_LIMIT = 64;
    localparam int BOARD_COLS      = 10;
    localparam int BOARD_ROWS      = 20;
    localparam int BOARD_CELLS     = BOARD_COLS * BOARD_ROWS;

    typedef struct packed {
        logic valid;
        logic is_scan;
    } rd_tag_t;

    // Row-major board cell address.
    function automatic logic [FB_ADDR_W-1:0] cell_addr(input int unsigned col, input int unsigned row);
        return FB_ADDR_W'(row * BOARD_COLS + col);
    endfunction
endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Two-stage return-tag shift register; stage 1 lines up with RAM read data.
module fb_rd_tag_pipe
    import fb_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);
    rd_tag_t r_s0;
    rd_tag_t r_s1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else begin
            r_s0 <= i_tag;
            r_s1 <= r_s0;
        end
    end

    assign o_tag = r_s1;
endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port board RAM arbiter: scanout reads always win, game reads/writes
// alternate round-robin, with a sticky flag for game requests left waiting.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
    input  logic              pixclk,
    input  logic              rst_n,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              gr_valid,
    input  logic [ADDR_W-1:0] gr_addr,
    output logic              gr_ready,
    output logic              gr_rvalid,
    output logic [DATA_W-1:0] gr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starved,
    input  logic              starved_clr
);
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic              r_last_game;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_scan_rvalid;
    logic              r_gr_rvalid;
    logic [DATA_W-1:0] r_scan_rdata;
    logic [DATA_W-1:0] r_gr_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_starved;

    logic              w_game_ok;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic [CNT_W-1:0]  w_cnt_nxt;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;

    // r_last_game: 0 = last game grant was a write, so a read goes next.
    assign w_game_ok = rst_n && !scan_req;
    assign w_gnt_wr  = w_game_ok && wr_valid && (!gr_valid || r_last_game);
    assign w_gnt_rd  = w_game_ok && gr_valid && (!wr_valid || !r_last_game);
    assign wr_ready  = w_gnt_wr;
    assign gr_ready  = w_gnt_rd;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_last_game <= 1'b0;
        end else begin
            r_mem_en <= scan_req | w_gnt_wr | w_gnt_rd;
            r_mem_we <= w_gnt_wr;
            if (scan_req) begin
                r_mem_addr <= scan_addr;
            end else if (w_gnt_wr) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end else if (w_gnt_rd) begin
                r_mem_addr <= gr_addr;
            end
            if (w_gnt_wr)      r_last_game <= 1'b0;
            else if (w_gnt_rd) r_last_game <= 1'b1;
        end
    end

    assign w_tag_in.valid   = scan_req | w_gnt_rd;
    assign w_tag_in.is_scan = scan_req;

    fb_rd_tag_pipe u_tag_pipe (
        .i_clk   (pixclk),
        .i_rst_n (rst_n),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            r_scan_rvalid <= 1'b0;
            r_gr_rvalid   <= 1'b0;
            r_scan_rdata  <= '0;
            r_gr_rdata    <= '0;
        end else begin
            r_scan_rvalid <= w_tag_out.valid && w_tag_out.is_scan;
            r_gr_rvalid   <= w_tag_out.valid && !w_tag_out.is_scan;
            if (w_tag_out.valid && w_tag_out.is_scan)  r_scan_rdata <= mem_rdata;
            if (w_tag_out.valid && !w_tag_out.is_scan) r_gr_rdata   <= mem_rdata;
        end
    end

    // Flag follows the counter's next value so both change on the same edge.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!(wr_valid || gr_valid) || w_gnt_wr || w_gnt_rd) w_cnt_nxt = '0;
        else if (r_cnt != CNT_MAX)                           w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_starved <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_MAX) r_starved <= 1'b1;
            else if (starved_clr)     r_starved <= 1'b0;
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign scan_rvalid = r_scan_rvalid;
    assign scan_rdata  = r_scan_rdata;
    assign gr_rvalid   = r_gr_rvalid;
    assign gr_rdata    = r_gr_rdata;
    assign starved     = r_starved;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural single-port RAM.
module tb_fb_access_arbiter;
    logic       pixclk = 1'b0;
    logic       rst_n;
    logic       scan_req;
    logic [7:0] scan_addr;
    logic       scan_rvalid;
    logic [3:0] scan_rdata;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       gr_valid;
    logic [7:0] gr_addr;
    logic       gr_ready;
    logic       gr_rvalid;
    logic [3:0] gr_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic       starved;
    logic       starved_clr;

    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [3:0] pl_data = '0;
    logic [3:0] ram [256];

    int n_chk = 0;
    int n_bad = 0;

    always #5 pixclk = ~pixclk;

    fb_access_arbiter dut (
        .pixclk(pixclk), .rst_n(rst_n),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .gr_valid(gr_valid), .gr_addr(gr_addr), .gr_ready(gr_ready),
        .gr_rvalid(gr_rvalid), .gr_rdata(gr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .starved(starved), .starved_clr(starved_clr)
    );

    always @(posedge pixclk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic       scan, wv, gv;
        logic       exp_wr, exp_gr, exp_en, exp_we;
        logic [7:0] exp_addr;
        logic [3:0] exp_wdata;
    } vec_t;
    vec_t tbl [12];

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [3:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " mem_en"}, mem_en, 0);
        chk({tag, " mem_we"}, mem_we, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " scan_rvalid"}, scan_rvalid, 0);
        chk({tag, " gr_rvalid"}, gr_rvalid, 0);
        chk({tag, " scan_rdata"}, scan_rdata, 0);
        chk({tag, " gr_rdata"}, gr_rdata, 0);
        chk({tag, " starved"}, starved, 0);
    endtask

    logic       e_sv [6];
    logic       e_gv [6];
    logic [3:0] e_d  [6];
    logic       flag;

    initial begin
        // scan, wv, gv | wr_rdy, gr_rdy | en, we, addr, wdata  (last_game starts 0)
        tbl[0]  = '{0,0,0, 0,0, 0,0, 8'h00, 4'h0};
        tbl[1]  = '{1,1,1, 0,0, 1,0, 8'h41, 4'h0};
        tbl[2]  = '{0,1,1, 0,1, 1,0, 8'hC2, 4'h0};
        tbl[3]  = '{0,1,1, 1,0, 1,1, 8'h83, 4'h3};
        tbl[4]  = '{0,1,1, 0,1, 1,0, 8'hC4, 4'h3};
        tbl[5]  = '{0,1,0, 1,0, 1,1, 8'h85, 4'h5};
        tbl[6]  = '{0,1,0, 1,0, 1,1, 8'h86, 4'h6};
        tbl[7]  = '{0,1,1, 0,1, 1,0, 8'hC7, 4'h6};
        tbl[8]  = '{0,0,1, 0,1, 1,0, 8'hC8, 4'h6};
        tbl[9]  = '{0,1,1, 1,0, 1,1, 8'h89, 4'h9};
        tbl[10] = '{1,0,1, 0,0, 1,0, 8'h4A, 4'h9};
        tbl[11] = '{0,0,0, 0,0, 0,0, 8'h4A, 4'h9};

        rst_n = 1'b0; scan_req = 0; scan_addr = '0; wr_valid = 0; wr_addr = '0;
        wr_data = '0; gr_valid = 0; gr_addr = '0; starved_clr = 0;
        tick(); tick();
        chk_reset_vals("reset");
        chk("reset wr_ready", wr_ready, 0);
        chk("reset gr_ready", gr_ready, 0);
        rst_n = 1'b1;

        // Arbitration / command table
        for (int i = 0; i < 12; i++) begin
            scan_req = tbl[i].scan; wr_valid = tbl[i].wv; gr_valid = tbl[i].gv;
            scan_addr = 8'h40 + 8'(i); wr_addr = 8'h80 + 8'(i);
            gr_addr = 8'hC0 + 8'(i); wr_data = 4'(i);
            #1;
            chk($sformatf("tbl%0d wr_ready", i), wr_ready, tbl[i].exp_wr);
            chk($sformatf("tbl%0d gr_ready", i), gr_ready, tbl[i].exp_gr);
            tick();
            chk($sformatf("tbl%0d mem_en", i), mem_en, tbl[i].exp_en);
            chk($sformatf("tbl%0d mem_we", i), mem_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d mem_wdata", i), mem_wdata, tbl[i].exp_wdata);
        end
        scan_req = 0; wr_valid = 0; gr_valid = 0;
        repeat (4) tick();

        // Single scan read, 3-cycle latency, data held afterwards
        preload(8'h05, 4'h3);
        scan_req = 1; scan_addr = 8'h05;
        tick();
        scan_req = 0;
        chk("scan1 mem_en", mem_en, 1);
        chk("scan1 mem_addr", mem_addr, 8'h05);
        tick();
        chk("scan1 early rvalid", scan_rvalid, 0);
        tick();
        chk("scan1 rvalid", scan_rvalid, 1);
        chk("scan1 rdata", scan_rdata, 4'h3);
        chk("scan1 gr_rvalid", gr_rvalid, 0);
        tick();
        chk("scan1 rvalid pulse", scan_rvalid, 0);
        chk("scan1 rdata hold", scan_rdata, 4'h3);

        // Write then read-after-write on the next cycle
        preload(8'h10, 4'h0);
        wr_valid = 1; wr_addr = 8'h10; wr_data = 4'h7;
        #1 chk("raw wr_ready", wr_ready, 1);
        tick();
        wr_valid = 0; gr_valid = 1; gr_addr = 8'h10;
        #1 chk("raw gr_ready", gr_ready, 1);
        tick();
        gr_valid = 0;
        tick();
        chk("raw early gr_rvalid", gr_rvalid, 0);
        tick();
        chk("raw gr_rvalid", gr_rvalid, 1);
        chk("raw gr_rdata", gr_rdata, 4'h7);
        chk("raw scan_rvalid", scan_rvalid, 0);

        // Scan reads 0..3 with one game read slotted in
        preload(8'h00, 4'h9); preload(8'h01, 4'hA);
        preload(8'h02, 4'hB); preload(8'h03, 4'hC);
        preload(8'h20, 4'h5);
        e_sv = '{1,1,0,1,1,0};
        e_gv = '{0,0,1,0,0,0};
        e_d  = '{4'h9, 4'hA, 4'h5, 4'hB, 4'hC, 4'h0};
        for (int c = 0; c < 8; c++) begin
            scan_req  = (c < 5) && (c != 2);
            scan_addr = (c < 2) ? 8'(c) : 8'(c - 1);
            gr_valid  = (c == 2);
            gr_addr   = 8'h20;
            #1;
            if (c == 2) chk("mix gr_ready", gr_ready, 1);
            tick();
            if (c >= 2) begin
                chk($sformatf("mix%0d scan_rvalid", c - 2), scan_rvalid, e_sv[c-2]);
                chk($sformatf("mix%0d gr_rvalid", c - 2), gr_rvalid, e_gv[c-2]);
                if (e_sv[c-2]) chk($sformatf("mix%0d scan_rdata", c - 2), scan_rdata, e_d[c-2]);
                if (e_gv[c-2]) chk($sformatf("mix%0d gr_rdata", c - 2), gr_rdata, e_d[c-2]);
            end
        end
        scan_req = 0; gr_valid = 0;
        tick();

        // Starvation: write held under 70 cycles of scanout
        flag = 1'b0;
        wr_addr = 8'h50; wr_data = 4'h1;
        for (int i = 0; i < 70; i++) begin
            scan_req = 1; scan_addr = 8'h00; wr_valid = 1;
            #1;
            if (wr_ready) flag = 1'b1;
            tick();
            if (i == 62) chk("starve before limit", starved, 0);
            if (i == 63) chk("starve at limit", starved, 1);
        end
        chk("starve wr_ready held low", flag, 0);
        scan_req = 0;
        #1 chk("starve wr accepted", wr_ready, 1);
        tick();
        wr_valid = 0;
        chk("starve sticky", starved, 1);
        repeat (3) tick();
        chk("starve still sticky", starved, 1);
        starved_clr = 1;
        tick();
        starved_clr = 0;
        chk("starve cleared", starved, 0);
        repeat (3) tick();

        // Reset one cycle after a scan read: the return must vanish
        scan_req = 1; scan_addr = 8'h05;
        tick();
        scan_req = 0; rst_n = 0; wr_valid = 1; gr_valid = 1;
        #1;
        chk("inrst wr_ready", wr_ready, 0);
        chk("inrst gr_ready", gr_ready, 0);
        tick();
        chk_reset_vals("midrst");
        rst_n = 1; wr_valid = 0; gr_valid = 0;
        flag = 1'b0;
        repeat (4) begin
            tick();
            if (scan_rvalid || gr_rvalid) flag = 1'b1;
        end
        chk("midrst no return", flag, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
